// File: rtl/alu_writeback.sv
// ALU writeback stage: in-order queue of ALU results retiring to the register-file
// write port, plus the architectural flags register and Jcc condition evaluation.
module alu_writeback #(
   parameter int         DEPTH       = 2,
   parameter logic [4:0] FLAGS_RESET = 5'b00000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_result,
   input  logic [4:0]                 in_status,
   input  logic [4:0]                 in_wr_flags,
   input  logic                       in_wr_reg,
   input  logic [2:0]                 in_dst,
   output logic                       rf_wr_en,
   output logic [2:0]                 rf_wr_idx,
   output logic [31:0]                rf_wr_data,
   input  logic                       rf_wr_ack,
   output logic [4:0]                 flags,
   input  logic [3:0]                 cc_sel,
   output logic                       cc_true,
   output logic [$clog2(DEPTH):0]     pending
);

   // Status/flags bit order.
   localparam int STAT_CF = 0;
   localparam int STAT_ZF = 1;
   localparam int STAT_SF = 2;
   localparam int STAT_OF = 3;
   localparam int STAT_PF = 4;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   result_mem   [DEPTH];
   logic [4:0]    status_mem   [DEPTH];
   logic [4:0]    wr_flags_mem [DEPTH];
   logic          wr_reg_mem   [DEPTH];
   logic [2:0]    dst_mem      [DEPTH];

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [4:0]    flags_q;

   logic          not_empty;
   logic          push;
   logic          pop;
   logic [31:0]   head_result;
   logic [4:0]    head_status;
   logic [4:0]    head_wr_flags;
   logic          head_wr_reg;
   logic [2:0]    head_dst;

   // Handshakes: an input entry transfers on a rising edge where in_valid & in_ready;
   // a register-file write completes on an edge where rf_wr_en & rf_wr_ack. in_ready
   // depends only on registered occupancy, so a pop never raises it in the same cycle.
   assign in_ready  = (count < DEPTH_C);
   assign not_empty = (count != '0);
   assign push      = in_valid & in_ready;

   assign head_result   = result_mem[rd_ptr];
   assign head_status   = status_mem[rd_ptr];
   assign head_wr_flags = wr_flags_mem[rd_ptr];
   assign head_wr_reg   = wr_reg_mem[rd_ptr];
   assign head_dst      = dst_mem[rd_ptr];

   assign pop        = not_empty & (~head_wr_reg | rf_wr_ack);
   assign rf_wr_en   = not_empty & head_wr_reg;
   assign rf_wr_idx  = not_empty ? head_dst : 3'd0;
   assign rf_wr_data = not_empty ? head_result : 32'd0;
   assign flags      = flags_q;
   assign pending    = count;

   // Payload storage needs no reset: every head output is qualified by occupancy.
   always_ff @(posedge clk) begin
      if (push) begin
         result_mem[wr_ptr]   <= in_result;
         status_mem[wr_ptr]   <= in_status;
         wr_flags_mem[wr_ptr] <= in_wr_flags;
         wr_reg_mem[wr_ptr]   <= in_wr_reg;
         dst_mem[wr_ptr]      <= in_dst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         flags_q <= FLAGS_RESET;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            flags_q <= (head_wr_flags & head_status) | (~head_wr_flags & flags_q);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      cc_true = 1'b0;
      case (cc_sel)
         4'h0: cc_true =  flags_q[STAT_OF];
         4'h1: cc_true = ~flags_q[STAT_OF];
         4'h2: cc_true =  flags_q[STAT_CF];
         4'h3: cc_true = ~flags_q[STAT_CF];
         4'h4: cc_true =  flags_q[STAT_ZF];
         4'h5: cc_true = ~flags_q[STAT_ZF];
         4'h6: cc_true =  (flags_q[STAT_CF] | flags_q[STAT_ZF]);
         4'h7: cc_true = ~(flags_q[STAT_CF] | flags_q[STAT_ZF]);
         4'h8: cc_true =  flags_q[STAT_SF];
         4'h9: cc_true = ~flags_q[STAT_SF];
         4'hA: cc_true =  flags_q[STAT_PF];
         4'hB: cc_true = ~flags_q[STAT_PF];
         4'hC: cc_true =  (flags_q[STAT_SF] ^ flags_q[STAT_OF]);
         4'hD: cc_true = ~(flags_q[STAT_SF] ^ flags_q[STAT_OF]);
         4'hE: cc_true =  (flags_q[STAT_ZF] | (flags_q[STAT_SF] ^ flags_q[STAT_OF]));
         4'hF: cc_true = ~(flags_q[STAT_ZF] | (flags_q[STAT_SF] ^ flags_q[STAT_OF]));
         default: cc_true = 1'b0;
      endcase
   end

endmodule
